// File: rtl/lock_on_tracker.sv
// Per-frame lock-on tracker: distance gating, exponential smoothing and a SEARCH/ACQUIRE/LOCKED/COAST FSM.
// Optional macro TRACK_SIZE_EN adds a smoothed pixel-count (track_size) register.
module lock_on_tracker #(
    parameter int ACQUIRE_FRAMES = 3,
    parameter int LOST_FRAMES    = 5,
    parameter int MAX_JUMP       = 24,
    parameter int SMOOTH_SHIFT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        calc_done,
    input  logic        target_valid,
    input  logic [7:0]  target_x,
    input  logic [6:0]  target_y,
    input  logic [15:0] pixel_count,
    output logic [7:0]  track_x,
    output logic [6:0]  track_y,
    output logic [1:0]  lock_state,
    output logic        locked,
    output logic        track_valid,
    output logic        update,
    output logic [15:0] track_size
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        COAST   = 2'd3
    } state_e;

    localparam logic [3:0] ACQ_N = 4'(ACQUIRE_FRAMES);
    localparam logic [3:0] LOST_N = 4'(LOST_FRAMES);
    localparam logic [9:0] MJ = 10'(MAX_JUMP);

    state_e      state_q, state_d;
    logic [3:0]  hit_q, hit_d;
    logic [3:0]  miss_q, miss_d;
    logic [7:0]  track_x_q, track_x_d;
    logic [6:0]  track_y_q, track_y_d;
    logic        update_q;
    logic        cd_q;
    logic        ev;
    logic        good;
    logic        gate_ok;
    logic        ld;
    logic        sm;
    logic [3:0]  hit_inc;
    logic [3:0]  miss_inc;

    logic signed [8:0] dx, sx;
    logic signed [7:0] dy, sy;
    logic [8:0]  adx;
    logic [7:0]  ady;

    assign ev = calc_done & ~cd_q;

    assign dx  = $signed({1'b0, target_x}) - $signed({1'b0, track_x_q});
    assign dy  = $signed({1'b0, target_y}) - $signed({1'b0, track_y_q});
    assign sx  = dx >>> SMOOTH_SHIFT;
    assign sy  = dy >>> SMOOTH_SHIFT;
    assign adx = dx[8] ? (~dx + 9'd1) : dx;
    assign ady = dy[7] ? (~dy + 8'd1) : dy;

    assign gate_ok = ({1'b0, adx} <= MJ) && ({2'b00, ady} <= MJ);
    // The gate only applies once a track exists.
    assign good = target_valid & ((state_q == SEARCH) | gate_ok);

    assign hit_inc  = hit_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            hit_q     <= '0;
            miss_q    <= '0;
            track_x_q <= '0;
            track_y_q <= '0;
            update_q  <= 1'b0;
            cd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            track_x_q <= track_x_d;
            track_y_q <= track_y_d;
            update_q  <= ev;
            cd_q      <= calc_done;
        end
    end

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        if (ev) begin
            unique case (state_q)
                SEARCH: begin
                    if (good) begin
                        state_d = ACQUIRE;
                        hit_d   = 4'd1;
                        miss_d  = '0;
                    end
                end
                ACQUIRE: begin
                    if (good) begin
                        hit_d = hit_inc;
                        if (hit_inc == ACQ_N) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                        hit_d   = '0;
                        miss_d  = '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_d = '0;
                    end else if (LOST_N == 4'd1) begin
                        state_d = SEARCH;
                        hit_d   = '0;
                        miss_d  = '0;
                    end else begin
                        state_d = COAST;
                        miss_d  = 4'd1;
                    end
                end
                COAST: begin
                    if (good) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end else if (miss_inc == LOST_N) begin
                        state_d = SEARCH;
                        hit_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            endcase
        end
    end

    // First hit loads the track directly; later hits are smoothed.
    always_comb begin
        ld = ev & good & (state_q == SEARCH);
        sm = ev & good & (state_q != SEARCH);
        track_x_d = track_x_q;
        track_y_d = track_y_q;
        if (ld) begin
            track_x_d = target_x;
            track_y_d = target_y;
        end else if (sm) begin
            track_x_d = 8'($unsigned(sx) + {1'b0, track_x_q});
            track_y_d = 7'($unsigned(sy) + {1'b0, track_y_q});
        end
    end

    assign track_x     = track_x_q;
    assign track_y     = track_y_q;
    assign lock_state  = state_q;
    assign locked      = state_q[1];
    assign track_valid = (state_q != SEARCH);
    assign update      = update_q;

`ifdef TRACK_SIZE_EN
    logic [15:0]        size_q, size_d;
    logic signed [16:0] ds, ss;

    assign ds = $signed({1'b0, pixel_count}) - $signed({1'b0, size_q});
    assign ss = ds >>> SMOOTH_SHIFT;

    always_comb begin
        size_d = size_q;
        if (ld)
            size_d = pixel_count;
        else if (sm)
            size_d = 16'($unsigned(ss) + {1'b0, size_q});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            size_q <= '0;
        else
            size_q <= size_d;
    end

    assign track_size = size_q;
`else
    logic unused_pc;
    assign unused_pc  = ^pixel_count;
    assign track_size = '0;
`endif

endmodule

// File: tb/tb_lock_on_tracker.sv
// Directed bench for lock_on_tracker: event table plus hand sequences for
// held calc_done, idle hold and asynchronous reset.
module tb_lock_on_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        calc_done;
    logic        target_valid;
    logic [7:0]  target_x;
    logic [6:0]  target_y;
    logic [15:0] pixel_count;
    logic [7:0]  track_x;
    logic [6:0]  track_y;
    logic [1:0]  lock_state;
    logic        locked;
    logic        track_valid;
    logic        update;
    logic [15:0] track_size;

    int n_run  = 0;
    int n_fail = 0;

`ifdef TRACK_SIZE_EN
    localparam bit SZ_EN = 1'b1;
`else
    localparam bit SZ_EN = 1'b0;
`endif

    lock_on_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .calc_done    (calc_done),
        .target_valid (target_valid),
        .target_x     (target_x),
        .target_y     (target_y),
        .pixel_count  (pixel_count),
        .track_x      (track_x),
        .track_y      (track_y),
        .lock_state   (lock_state),
        .locked       (locked),
        .track_valid  (track_valid),
        .update       (update),
        .track_size   (track_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int x;
        int y;
        int pc;
        int st;
        int tx;
        int ty;
        int sz;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_event(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        target_valid = v.v;
        target_x     = 8'(v.x);
        target_y     = 7'(v.y);
        pixel_count  = 16'(v.pc);
        calc_done    = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".update"}, 32'(update), 1);
        chk({tag, ".state"}, 32'(lock_state), v.st);
        chk({tag, ".tx"}, 32'(track_x), v.tx);
        chk({tag, ".ty"}, 32'(track_y), v.ty);
        chk({tag, ".locked"}, 32'(locked), (v.st >= 2) ? 1 : 0);
        chk({tag, ".tvalid"}, 32'(track_valid), (v.st != 0) ? 1 : 0);
        chk({tag, ".size"}, 32'(track_size), SZ_EN ? v.sz : 0);
        calc_done = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".upd_off"}, 32'(update), 0);
    endtask

    int pulses;
    vec_t ev;

    initial begin
        tbl[0]  = '{1, 80, 60, 400, 1, 80, 60, 400};
        tbl[1]  = '{1, 88, 64, 800, 1, 82, 61, 500};
        tbl[2]  = '{1, 82, 61, 500, 2, 82, 61, 500};
        tbl[3]  = '{1, 120, 61, 500, 3, 82, 61, 500};
        tbl[4]  = '{1, 82, 61, 500, 2, 82, 61, 500};
        tbl[5]  = '{1, 81, 61, 500, 2, 81, 61, 500};
        tbl[6]  = '{1, 83, 61, 500, 2, 81, 61, 500};
        tbl[7]  = '{1, 105, 61, 500, 2, 87, 61, 500};
        tbl[8]  = '{1, 120, 61, 900, 3, 87, 61, 500};
        tbl[9]  = '{0, 87, 61, 900, 3, 87, 61, 500};
        tbl[10] = '{0, 87, 61, 900, 3, 87, 61, 500};
        tbl[11] = '{0, 87, 61, 900, 3, 87, 61, 500};
        tbl[12] = '{0, 87, 61, 900, 0, 87, 61, 500};
        tbl[13] = '{0, 20, 20, 900, 0, 87, 61, 500};
        tbl[14] = '{1, 10, 5, 100, 1, 10, 5, 100};
        tbl[15] = '{0, 10, 5, 900, 0, 10, 5, 100};

        reset        = 1'b1;
        calc_done    = 1'b0;
        target_valid = 1'b0;
        target_x     = '0;
        target_y     = '0;
        pixel_count  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.state", 32'(lock_state), 0);
        chk("rst.tx", 32'(track_x), 0);
        chk("rst.ty", 32'(track_y), 0);
        chk("rst.size", 32'(track_size), 0);
        chk("rst.update", 32'(update), 0);
        chk("rst.tvalid", 32'(track_valid), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++)
            do_event(tbl[i], $sformatf("v%0d", i));

        // calc_done held high for 10 cycles yields a single event
        @(posedge clk);
        #1;
        target_valid = 1'b1;
        target_x     = 8'd80;
        target_y     = 7'd60;
        pixel_count  = 16'd400;
        calc_done    = 1'b1;
        pulses       = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            pulses += int'(update);
        end
        calc_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            pulses += int'(update);
        end
        chk("held.pulses", 32'(pulses), 1);
        chk("held.state", 32'(lock_state), 1);
        chk("held.tx", 32'(track_x), 80);
        chk("held.ty", 32'(track_y), 60);

        ev = '{1, 80, 60, 400, 1, 80, 60, 400};
        do_event(ev, "acq2");
        ev = '{1, 80, 60, 400, 2, 80, 60, 400};
        do_event(ev, "acq3");

        repeat (5) @(posedge clk);
        #1;
        chk("idle.state", 32'(lock_state), 2);
        chk("idle.update", 32'(update), 0);
        chk("idle.tx", 32'(track_x), 80);

        // async reset in the middle of an event
        target_x  = 8'd90;
        calc_done = 1'b1;
        reset     = 1'b1;
        #1;
        chk("arst.state", 32'(lock_state), 0);
        chk("arst.tx", 32'(track_x), 0);
        @(posedge clk);
        #1;
        chk("arst.update", 32'(update), 0);
        chk("arst.locked", 32'(locked), 0);
        chk("arst.tvalid", 32'(track_valid), 0);
        chk("arst.ty", 32'(track_y), 0);
        calc_done = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
